// File: rtl/ace_audio_mixer_dac.sv
// Jupiter Ace audio back end: mixes AY channels with beeper/tape bits into
// saturated 10-bit L/R PCM and drives each through a first-order sigma-delta.
module ace_audio_mixer_dac #(
    parameter int         STEREO    = 1,
    parameter logic [7:0] SPK_LEVEL = 8'd96,
    parameter logic [7:0] MIC_LEVEL = 8'd32,
    parameter logic [7:0] EAR_LEVEL = 8'd32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_sample,
    input  logic [7:0] ay_a,
    input  logic [7:0] ay_b,
    input  logic [7:0] ay_c,
    input  logic       spk,
    input  logic       mic,
    input  logic       ear,
    input  logic       mute,
    output logic [9:0] pcm_l,
    output logic [9:0] pcm_r,
    output logic       pcm_valid,
    output logic       audio_l,
    output logic       audio_r
);

    logic [1:0]       ear_sync_q, ear_sync_d;
    logic [7:0]       a_q, a_d, b_q, b_d, c_q, c_d;
    logic             spk_q, spk_d, mic_q, mic_d, ear_q, ear_d, mute_q, mute_d;
    logic [1:0]       vld_pipe_q, vld_pipe_d;
    logic [1:0][9:0]  pcm_q, pcm_d;
    logic [1:0][10:0] acc_q, acc_d;
    logic [1:0]       audio_q, audio_d;
    logic [11:0]      beep, sum_l, sum_r;

    function automatic logic [9:0] sat10(input logic [11:0] s);
        return (s > 12'd1023) ? 10'h3FF : s[9:0];
    endfunction

    always_comb begin
        ear_sync_d = {ear_sync_q[0], ear};
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        spk_d      = spk_q;
        mic_d      = mic_q;
        ear_d      = ear_q;
        mute_d     = mute_q;
        if (ce_sample) begin
            a_d    = ay_a;
            b_d    = ay_b;
            c_d    = ay_c;
            spk_d  = spk;
            mic_d  = mic;
            ear_d  = ear_sync_q[1];
            mute_d = mute;
        end
        vld_pipe_d = {vld_pipe_q[0], ce_sample};
    end

    always_comb begin
        beep = 12'd0;
        if (spk_q) beep = beep + {4'd0, SPK_LEVEL};
        if (mic_q) beep = beep + {4'd0, MIC_LEVEL};
        if (ear_q) beep = beep + {4'd0, EAR_LEVEL};
    end

    generate
        if (STEREO != 0) begin : g_stereo
            // ACB layout: B is centred, split half into each side
            assign sum_l = {4'd0, a_q} + ({4'd0, b_q} >> 1) + beep;
            assign sum_r = {4'd0, c_q} + ({4'd0, b_q} >> 1) + beep;
        end else begin : g_mono
            assign sum_l = {4'd0, a_q} + {4'd0, b_q} + {4'd0, c_q} + beep;
            assign sum_r = sum_l;
        end
    endgenerate

    always_comb begin
        pcm_d = pcm_q;
        if (vld_pipe_q[0]) begin
            if (mute_q) begin
                pcm_d = '0;
            end else begin
                pcm_d[0] = sat10(sum_l);
                pcm_d[1] = sat10(sum_r);
            end
        end
    end

    // Carry out of a 10-bit wraparound accumulator is the bitstream; the
    // accumulator is never cleared on pcm change, so density tracks pcm/1024.
    always_comb begin
        acc_d   = '0;
        audio_d = '0;
        for (int i = 0; i < 2; i++) begin
            acc_d[i]   = {1'b0, acc_q[i][9:0]} + {1'b0, pcm_q[i]};
            audio_d[i] = acc_d[i][10];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ear_sync_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            spk_q      <= 1'b0;
            mic_q      <= 1'b0;
            ear_q      <= 1'b0;
            mute_q     <= 1'b0;
            vld_pipe_q <= '0;
            pcm_q      <= '0;
            acc_q      <= '0;
            audio_q    <= '0;
        end else begin
            ear_sync_q <= ear_sync_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            spk_q      <= spk_d;
            mic_q      <= mic_d;
            ear_q      <= ear_d;
            mute_q     <= mute_d;
            vld_pipe_q <= vld_pipe_d;
            pcm_q      <= pcm_d;
            acc_q      <= acc_d;
            audio_q    <= audio_d;
        end
    end

    assign pcm_l     = pcm_q[0];
    assign pcm_r     = pcm_q[1];
    assign pcm_valid = vld_pipe_q[1];
    assign audio_l   = audio_q[0];
    assign audio_r   = audio_q[1];

endmodule

// File: tb/tb_ace_audio_mixer_dac.sv
// Bench for ace_audio_mixer_dac: a stereo instance with default levels and a
// mono instance with all levels at 255, both driven from the same inputs.
module tb_ace_audio_mixer_dac;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_sample = 1'b0;
    logic [7:0] ay_a = '0, ay_b = '0, ay_c = '0;
    logic       spk = 1'b0, mic = 1'b0, ear = 1'b0, mute = 1'b0;
    logic [9:0] pcm_l, pcm_r, pcm_lm, pcm_rm;
    logic       pcm_valid, pcm_valid_m, audio_l, audio_r, audio_lm, audio_rm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ace_audio_mixer_dac dut_st (
        .clk(clk), .reset(reset), .ce_sample(ce_sample),
        .ay_a(ay_a), .ay_b(ay_b), .ay_c(ay_c),
        .spk(spk), .mic(mic), .ear(ear), .mute(mute),
        .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid),
        .audio_l(audio_l), .audio_r(audio_r)
    );

    ace_audio_mixer_dac #(.STEREO(0), .SPK_LEVEL(8'd255), .MIC_LEVEL(8'd255),
                          .EAR_LEVEL(8'd255)) dut_mn (
        .clk(clk), .reset(reset), .ce_sample(ce_sample),
        .ay_a(ay_a), .ay_b(ay_b), .ay_c(ay_c),
        .spk(spk), .mic(mic), .ear(ear), .mute(mute),
        .pcm_l(pcm_lm), .pcm_r(pcm_rm), .pcm_valid(pcm_valid_m),
        .audio_l(audio_lm), .audio_r(audio_rm)
    );

    // Reference mix from the mixing rules, in plain integer arithmetic.
    function automatic int mix(input bit stereo, input int lvl_s, input int lvl_m,
                               input int lvl_e, input int a, input int b, input int c,
                               input bit s, input bit m, input bit e, input bit mt,
                               input bit right);
        int beep, sum;
        beep = (s ? lvl_s : 0) + (m ? lvl_m : 0) + (e ? lvl_e : 0);
        if (stereo) sum = (right ? c : a) + b / 2 + beep;
        else        sum = a + b + c + beep;
        if (mt) return 0;
        return (sum > 1023) ? 1023 : sum;
    endfunction

    function automatic int mix_st(input int a, input int b, input int c, input bit s,
                                  input bit m, input bit e, input bit mt, input bit right);
        return mix(1'b1, 96, 32, 32, a, b, c, s, m, e, mt, right);
    endfunction

    function automatic int mix_mn(input int a, input int b, input int c, input bit s,
                                  input bit m, input bit e, input bit mt);
        return mix(1'b0, 255, 255, 255, a, b, c, s, m, e, mt, 1'b0);
    endfunction

    // One-clk strobe; returns 1 time unit after the capturing edge.
    task automatic strobe(input int a, input int b, input int c, input bit s,
                          input bit m, input bit mt);
        @(posedge clk); #1;
        ay_a = a[7:0]; ay_b = b[7:0]; ay_c = c[7:0];
        spk = s; mic = m; mute = mt; ce_sample = 1'b1;
        @(posedge clk); #1;
        ce_sample = 1'b0;
    endtask

    task automatic count_ones(input int n, output int ol, output int orr, output int om);
        ol = 0; orr = 0; om = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ol += int'(audio_l); orr += int'(audio_r); om += int'(audio_lm);
        end
    endtask

    task automatic test_reset;
        int pulses;
        reset = 1'b1; ay_a = 8'hFF; spk = 1'b1; ce_sample = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({pcm_l, pcm_r, pcm_valid, audio_l, audio_r, pcm_lm, pcm_valid_m, audio_lm} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: pcm_l=%0d pcm_r=%0d v=%b al=%b ar=%b mono=%0d required all 0",
                     pcm_l, pcm_r, pcm_valid, audio_l, audio_r, pcm_lm);
        end
        ce_sample = 1'b0;
        @(negedge clk); reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (pcm_valid || pcm_valid_m || pcm_l != 0 || pcm_r != 0) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_release: %0d cycles with valid/pcm active, required 0", pulses);
        end
        ay_a = 8'h00; spk = 1'b0;
    endtask

    task automatic test_single;
        strobe(200, 100, 10, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (pcm_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_early_valid: got %b required 0", pcm_valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if (pcm_valid !== 1'b1 || pcm_l !== 10'd346 || pcm_r !== 10'd156) begin
            n_fail++;
            $display("FAIL single_pcm: v=%b l=%0d r=%0d required v=1 l=346 r=156",
                     pcm_valid, pcm_l, pcm_r);
        end
        n_tests++;
        if (pcm_lm !== 10'(mix_mn(200, 100, 10, 1, 0, 0, 0))) begin
            n_fail++; $display("FAIL single_mono: got %0d required %0d", pcm_lm,
                               mix_mn(200, 100, 10, 1, 0, 0, 0));
        end
        @(posedge clk); #1;
        n_tests++;
        if (pcm_valid !== 1'b0 || pcm_l !== 10'd346) begin
            n_fail++; $display("FAIL single_pulse_width: v=%b l=%0d required v=0 l=346",
                               pcm_valid, pcm_l);
        end
    endtask

    task automatic test_saturate;
        strobe(255, 255, 255, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        n_tests++;
        if (pcm_lm !== 10'd1023 || pcm_rm !== 10'd1023 ||
            pcm_l !== 10'(mix_st(255, 255, 255, 1, 1, 0, 0, 0))) begin
            n_fail++;
            $display("FAIL saturate: mono l=%0d r=%0d stereo l=%0d required 1023 1023 %0d",
                     pcm_lm, pcm_rm, pcm_l, mix_st(255, 255, 255, 1, 1, 0, 0, 0));
        end
        strobe(0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_tests++;
        if (pcm_lm !== 10'd0 || pcm_rm !== 10'd0 || pcm_l !== 10'd0 || pcm_r !== 10'd0) begin
            n_fail++;
            $display("FAIL saturate_zero: mono l=%0d r=%0d stereo l=%0d r=%0d required 0",
                     pcm_lm, pcm_rm, pcm_l, pcm_r);
        end
    endtask

    task automatic test_mute;
        int bad;
        strobe(255, 0, 0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (pcm_l !== 10'd0 || pcm_r !== 10'd0 || pcm_lm !== 10'd0) begin
            n_fail++; $display("FAIL mute_pcm: l=%0d r=%0d mono=%0d required 0", pcm_l, pcm_r, pcm_lm);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (audio_l || audio_r || audio_lm) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL mute_audio: %0d ones seen, required 0", bad);
        end
        strobe(255, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_tests++;
        if (pcm_l !== 10'(mix_st(255, 0, 0, 0, 0, 0, 0, 0)) || pcm_valid !== 1'b1) begin
            n_fail++; $display("FAIL unmute: l=%0d v=%b required %0d v=1", pcm_l, pcm_valid,
                               mix_st(255, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_sigma_delta;
        int ol, orr, om, a, b, c, el, er, em, bad;
        bit s, m;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin a = 160; b = 0; c = 0; s = 1; m = 0; end
            else if (k == 1) begin a = 255; b = 255; c = 255; s = 0; m = 0; end
            else begin
                a = $urandom_range(0, 255); b = $urandom_range(0, 255);
                c = $urandom_range(0, 255); s = 1'($urandom); m = 1'($urandom);
            end
            strobe(a, b, c, s, m, 1'b0);
            repeat (4) @(posedge clk);
            el = mix_st(a, b, c, s, m, 0, 0, 0);
            er = mix_st(a, b, c, s, m, 0, 0, 1);
            em = mix_mn(a, b, c, s, m, 0, 0);
            count_ones(1024, ol, orr, om);
            n_tests++;
            if (ol != el || orr != er || om != em) begin
                n_fail++;
                $display("FAIL sd_density[%0d]: ones l=%0d r=%0d mono=%0d required %0d %0d %0d",
                         k, ol, orr, om, el, er, em);
            end
        end
        strobe(0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk);
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            @(posedge clk); #1;
            if (audio_l || audio_r || audio_lm) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL sd_zero: %0d ones in 4096 clks, required 0", bad);
        end
    endtask

    task automatic test_ear;
        int n, exp_l;
        ay_a = 0; ay_b = 0; ay_c = 0; spk = 0; mic = 0; mute = 0; ear = 0;
        @(posedge clk); #1; ce_sample = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_tests++;
        if (pcm_l !== 10'd0) begin
            n_fail++; $display("FAIL ear_idle: l=%0d required 0", pcm_l);
        end
        for (int k = 0; k < 4; k++) begin
            #($urandom_range(1, 7));
            ear = ~ear;
            exp_l = ear ? 32 : 0;
            n = 0;
            while (n < 10) begin
                @(posedge clk); n++; #1;
                if (pcm_l == 10'(exp_l)) break;
            end
            n_tests++;
            if (n < 4 || n > 5 || pcm_l !== 10'(exp_l)) begin
                n_fail++;
                $display("FAIL ear_latency[%0d]: l=%0d after %0d edges, required %0d after 4..5",
                         k, pcm_l, n, exp_l);
            end
            repeat (3) @(posedge clk);
            #1;
        end
        ce_sample = 1'b0;
    endtask

    task automatic test_back_to_back;
        int  hl[2], hr[2], hm[2];
        bit  hv[2];
        int  last_l, last_r, last_m, a, b, c;
        bit  have, ce, s, m, mt, ev;
        hv = '{0, 0}; have = 0; last_l = 0; last_r = 0; last_m = 0;
        ev = 1'($urandom); ear = ev;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (pcm_valid !== hv[1] || pcm_valid_m !== hv[1]) begin
                n_fail++; $display("FAIL b2b_valid[%0d]: got %b/%b required %b",
                                   i, pcm_valid, pcm_valid_m, hv[1]);
            end
            if (hv[1]) begin
                last_l = hl[1]; last_r = hr[1]; last_m = hm[1]; have = 1;
            end
            if (have) begin
                n_tests++;
                if (pcm_l !== 10'(last_l) || pcm_r !== 10'(last_r) ||
                    pcm_lm !== 10'(last_m) || pcm_rm !== 10'(last_m)) begin
                    n_fail++;
                    $display("FAIL b2b_pcm[%0d]: l=%0d r=%0d ml=%0d mr=%0d required %0d %0d %0d %0d",
                             i, pcm_l, pcm_r, pcm_lm, pcm_rm, last_l, last_r, last_m, last_m);
                end
            end
            a = $urandom_range(0, 255); b = $urandom_range(0, 255); c = $urandom_range(0, 255);
            s = 1'($urandom); m = 1'($urandom); mt = ($urandom_range(0, 7) == 0);
            ce = (i == 0) || ($urandom_range(0, 2) != 0);
            ay_a = a[7:0]; ay_b = b[7:0]; ay_c = c[7:0]; spk = s; mic = m; mute = mt;
            ce_sample = ce;
            hv[1] = hv[0]; hl[1] = hl[0]; hr[1] = hr[0]; hm[1] = hm[0];
            hv[0] = ce;
            hl[0] = mix_st(a, b, c, s, m, ev, mt, 0);
            hr[0] = mix_st(a, b, c, s, m, ev, mt, 1);
            hm[0] = mix_mn(a, b, c, s, m, ev, mt);
        end
        @(posedge clk); #1; ce_sample = 1'b0;
    endtask

    task automatic test_mid_reset;
        int bad;
        strobe(100, 0, 0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        n_tests++;
        if ({pcm_l, pcm_r, pcm_valid, audio_l, audio_r} !== '0) begin
            n_fail++; $display("FAIL mid_reset_clear: l=%0d r=%0d v=%b required 0", pcm_l, pcm_r, pcm_valid);
        end
        @(negedge clk); reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (pcm_valid || pcm_valid_m || pcm_l != 0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL mid_reset_drop: %0d cycles with stale sample, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturate();
        test_mute();
        test_sigma_delta();
        test_ear();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
